// File: rtl/ysyx_23060025_icache_pkg.sv
// Shared parameters, FSM encoding and AXI constants for the instruction cache.
// Optional feature macro used by the cache: YSYX_ICACHE_FENCEI_EN.
package ysyx_23060025_icache_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int OFFSET_WIDTH = 4;
  localparam int INDEX_WIDTH  = 4;
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORD_WIDTH   = OFFSET_WIDTH - 2;
  localparam int NUM_LINES    = 1 << INDEX_WIDTH;
  localparam int LINE_WORDS   = 1 << WORD_WIDTH;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_LINE   = 8'(LINE_WORDS - 1);

  // Word address: byte address with the always-zero bits [1:0] dropped.
  typedef logic [ADDR_WIDTH-1:2] waddr_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_AR_REQ = 3'd2,
    ST_R_FILL = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [TAG_WIDTH-1:0] tag,
                                                      input logic [INDEX_WIDTH-1:0] idx);
    return {tag, idx, {OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/ysyx_23060025_icache_data_array.sv
// Line storage for the instruction cache: one write port fed by the refill
// beats, one asynchronous read port shared by lookup and response.
module ysyx_23060025_icache_data_array
  import ysyx_23060025_icache_pkg::*;
#(
  parameter int IDX_W  = INDEX_WIDTH,
  parameter int WORD_W = WORD_WIDTH,
  parameter int DW     = DATA_WIDTH
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  w_idx,
  input  logic [WORD_W-1:0] w_word,
  input  logic [DW-1:0]     w_data,
  input  logic [IDX_W-1:0]  r_idx,
  input  logic [WORD_W-1:0] r_word,
  output logic [DW-1:0]     r_data
);

  logic [DW-1:0] mem_r [1 << IDX_W][1 << WORD_W];

  // Refill beat write; contents are meaningful only under a set valid bit.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[w_idx][w_word] <= w_data;
    end
  end

  assign r_data = mem_r[r_idx][r_word];

endmodule

// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped read-only instruction cache with AXI4 INCR line refill.
// Define YSYX_ICACHE_FENCEI_EN to let fencei_i invalidate every line.
module ysyx_23060025_icache
  import ysyx_23060025_icache_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] in_paddr,
  input  logic                  in_psel,
  output logic                  out_pready,
  output logic [DATA_WIDTH-1:0] out_prdata,
  input  logic                  fencei_i,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  input  logic                  rlast,
  output logic                  rready
);

  state_e                  state_r, state_nxt_s;
  waddr_t                  req_addr_r, lk_addr_s;
  logic [NUM_LINES-1:0]    valid_r;
  logic [TAG_WIDTH-1:0]    tag_r [NUM_LINES];
  logic [WORD_WIDTH-1:0]   beat_cnt_r;
  logic                    err_r;
  logic                    pready_r, pready_nxt_s, arvalid_r, arvalid_nxt_s, rready_r, rready_nxt_s;
  logic [DATA_WIDTH-1:0]   prdata_r, prdata_nxt_s, rd_data_s;
  logic [ADDR_WIDTH-1:0]   araddr_r, araddr_nxt_s;
  logic [INDEX_WIDTH-1:0]  lk_idx_s, req_idx_s;
  logic [TAG_WIDTH-1:0]    lk_tag_s, req_tag_s;
  logic [WORD_WIDTH-1:0]   lk_word_s, req_word_s;
  logic                    hit_s, beat_fire_s, last_fire_s, ar_fire_s, fill_ok_s;
  logic                    fence_now_s, clear_all_s, unused_s;

  assign req_idx_s   = req_addr_r[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
  assign req_tag_s   = req_addr_r[ADDR_WIDTH-1:OFFSET_WIDTH+INDEX_WIDTH];
  assign req_word_s  = req_addr_r[OFFSET_WIDTH-1:2];
  assign ar_fire_s   = arvalid_r & arready;
  assign beat_fire_s = rready_r & rvalid;
  assign last_fire_s = beat_fire_s & rlast;
  // A short burst (early rlast) or any error beat leaves the line invalid.
  assign fill_ok_s   = ~err_r & (rresp == AXI_RESP_OKAY) & (beat_cnt_r == WORD_WIDTH'(LINE_WORDS - 1));

`ifdef YSYX_ICACHE_FENCEI_EN
  logic flush_pend_r;

  assign fence_now_s = fencei_i;
  assign clear_all_s = (fencei_i & ((state_r == ST_IDLE) | (state_r == ST_LOOKUP)))
                     | ((state_r == ST_RESP) & (flush_pend_r | fencei_i));
  assign unused_s    = ^in_paddr[1:0];

  // Fence seen while a refill is in flight is deferred to the return to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_pend_r <= 1'b0;
    end else if (state_r == ST_RESP) begin
      flush_pend_r <= 1'b0;
    end else if (fencei_i & ((state_r == ST_AR_REQ) | (state_r == ST_R_FILL))) begin
      flush_pend_r <= 1'b1;
    end
  end
`else
  assign fence_now_s = 1'b0;
  assign clear_all_s = 1'b0;
  assign unused_s    = ^{in_paddr[1:0], fencei_i};
`endif

  // Lookup address: the live fetch address in IDLE, the held request otherwise.
  always_comb begin
    lk_addr_s = req_addr_r;
    if (state_r == ST_IDLE) begin
      lk_addr_s = in_paddr[ADDR_WIDTH-1:2];
    end else begin
      lk_addr_s = req_addr_r;
    end
    lk_idx_s  = lk_addr_s[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
    lk_tag_s  = lk_addr_s[ADDR_WIDTH-1:OFFSET_WIDTH+INDEX_WIDTH];
    lk_word_s = lk_addr_s[OFFSET_WIDTH-1:2];
    hit_s     = valid_r[lk_idx_s] & (tag_r[lk_idx_s] == lk_tag_s) & ~fence_now_s;
  end

  ysyx_23060025_icache_data_array u_data (
    .clock  (clock),
    .we     (beat_fire_s),
    .w_idx  (req_idx_s),
    .w_word (beat_cnt_r),
    .w_data (rdata),
    .r_idx  (lk_idx_s),
    .r_word (lk_word_s),
    .r_data (rd_data_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic; in LOOKUP the registered pready carries the hit decision.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = in_psel ? ST_LOOKUP : ST_IDLE;
      ST_LOOKUP: state_nxt_s = pready_r ? ST_IDLE : ST_AR_REQ;
      ST_AR_REQ: state_nxt_s = ar_fire_s ? ST_R_FILL : ST_AR_REQ;
      ST_R_FILL: state_nxt_s = last_fire_s ? ST_RESP : ST_R_FILL;
      ST_RESP:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Output lookahead: values the registered outputs take on the next edge.
  always_comb begin
    pready_nxt_s  = 1'b0;
    prdata_nxt_s  = prdata_r;
    arvalid_nxt_s = arvalid_r;
    araddr_nxt_s  = araddr_r;
    rready_nxt_s  = rready_r;
    case (state_r)
      ST_IDLE: begin
        if (in_psel & hit_s) begin
          pready_nxt_s = 1'b1;
          prdata_nxt_s = rd_data_s;
        end else begin
          pready_nxt_s = 1'b0;
        end
      end
      ST_LOOKUP: begin
        if (!pready_r) begin
          arvalid_nxt_s = 1'b1;
          araddr_nxt_s  = line_base(req_tag_s, req_idx_s);
        end else begin
          arvalid_nxt_s = 1'b0;
        end
      end
      ST_AR_REQ: begin
        if (arready) begin
          arvalid_nxt_s = 1'b0;
          rready_nxt_s  = 1'b1;
        end else begin
          arvalid_nxt_s = 1'b1;
        end
      end
      ST_R_FILL: begin
        if (last_fire_s) begin
          rready_nxt_s = 1'b0;
          pready_nxt_s = 1'b1;
          prdata_nxt_s = (beat_cnt_r == req_word_s) ? rdata : rd_data_s;
        end else begin
          rready_nxt_s = 1'b1;
        end
      end
      ST_RESP: pready_nxt_s = 1'b0;
      default: begin
        arvalid_nxt_s = 1'b0;
        rready_nxt_s  = 1'b0;
      end
    endcase
  end

  // Registered port outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      pready_r  <= 1'b0;
      prdata_r  <= {DATA_WIDTH{1'b0}};
      arvalid_r <= 1'b0;
      araddr_r  <= {ADDR_WIDTH{1'b0}};
      rready_r  <= 1'b0;
    end else begin
      pready_r  <= pready_nxt_s;
      prdata_r  <= prdata_nxt_s;
      arvalid_r <= arvalid_nxt_s;
      araddr_r  <= araddr_nxt_s;
      rready_r  <= rready_nxt_s;
    end
  end

  // Request capture and refill beat bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_addr_r <= {(ADDR_WIDTH-2){1'b0}};
      beat_cnt_r <= {WORD_WIDTH{1'b0}};
      err_r      <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) & in_psel) req_addr_r <= in_paddr[ADDR_WIDTH-1:2];
      if (ar_fire_s) begin
        beat_cnt_r <= {WORD_WIDTH{1'b0}};
        err_r      <= 1'b0;
      end else if (beat_fire_s) begin
        beat_cnt_r <= beat_cnt_r + WORD_WIDTH'(1);
        err_r      <= err_r | (rresp != AXI_RESP_OKAY);
      end
    end
  end

  // Valid bits: reset and fence clear everything, a finished refill sets one line.
  always_ff @(posedge clock) begin
    if (reset | clear_all_s) valid_r <= {NUM_LINES{1'b0}};
    else if (last_fire_s)    valid_r[req_idx_s] <= fill_ok_s;
  end

  // Tag array, not reset.
  always_ff @(posedge clock) begin
    if (last_fire_s) tag_r[req_idx_s] <= req_tag_s;
  end

  assign out_pready = pready_r;
  assign out_prdata = prdata_r;
  assign arvalid    = arvalid_r;
  assign araddr     = araddr_r;
  assign rready     = rready_r;
  assign arlen      = AXI_LEN_LINE;
  assign arsize     = AXI_SIZE_4B;
  assign arburst    = AXI_BURST_INCR;

endmodule
